// File: rtl/relu_bwd.sv
// relu_bwd: ReLU backward gate; forward-tap mask FIFO gates the upstream gradient stream.
module relu_bwd #(
  parameter int DATA_WIDTH = 12,
  parameter int MASK_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          fwd_ready_in,
  input  logic                          fwd_valid_in,
  input  logic [DATA_WIDTH-1:0]         fwd_data_in,
  output logic                          grad_ready_in,
  input  logic                          grad_valid_in,
  input  logic [DATA_WIDTH-1:0]         grad_data_in,
  input  logic                          grad_ready_out,
  output logic                          grad_valid_out,
  output logic [DATA_WIDTH-1:0]         grad_data_out,
  input  logic                          flush,
  output logic [$clog2(MASK_DEPTH):0]   mask_count
);
  localparam int AW = $clog2(MASK_DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [MASK_DEPTH-1:0] mem;
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, out_free, push, pop, unused_bits;
  assign unused_bits = ^fwd_data_in[DATA_WIDTH-2:0];
  // MSB differs with equal low bits means the writer has lapped the reader
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_free = ~grad_valid_out | grad_ready_out;
  assign fwd_ready_in = ~rst & ~flush & ~full;
  assign grad_ready_in = ~rst & ~flush & ~empty & out_free;
  assign push = fwd_valid_in & fwd_ready_in;
  assign pop = grad_valid_in & grad_ready_in;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      mask_count <= '0;
      grad_valid_out <= 1'b0;
      grad_data_out <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        mask_count <= '0;
      end else begin
        if (push) mem[wr_ptr[AW-1:0]] <= ~fwd_data_in[DATA_WIDTH-1];
        if (push) wr_ptr <= wr_ptr + ONE;
        if (pop) rd_ptr <= rd_ptr + ONE;
        mask_count <= (push & ~pop) ? mask_count + ONE : (pop & ~push) ? mask_count - ONE : mask_count;
      end
      if (pop) begin
        grad_valid_out <= 1'b1;
        grad_data_out <= mem[rd_ptr[AW-1:0]] ? grad_data_in : '0;
      end else if (grad_ready_out) begin
        grad_valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_relu_bwd.sv
// tb_relu_bwd: scoreboard bench for relu_bwd with a 4-deep mask FIFO.
module tb_relu_bwd;
  localparam int DW = 12;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, flush = 0;
  logic fwd_ready_in, fwd_valid_in = 0;
  logic [DW-1:0] fwd_data_in = 0;
  logic grad_ready_in, grad_valid_in = 0, grad_ready_out = 1, grad_valid_out;
  logic [DW-1:0] grad_data_in = 0, grad_data_out;
  logic [$clog2(DEPTH):0] mask_count;
  int n_chk = 0, n_fail = 0;
  bit mq[$];
  logic [DW-1:0] sbq[$];
  bit ov = 0, e_frdy, e_grdy, m;

  relu_bwd #(.DATA_WIDTH(DW), .MASK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fwd_ready_in(fwd_ready_in), .fwd_valid_in(fwd_valid_in), .fwd_data_in(fwd_data_in),
    .grad_ready_in(grad_ready_in), .grad_valid_in(grad_valid_in), .grad_data_in(grad_data_in),
    .grad_ready_out(grad_ready_out), .grad_valid_out(grad_valid_out), .grad_data_out(grad_data_out),
    .flush(flush), .mask_count(mask_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_fwd(input logic [DW-1:0] d);
    fwd_valid_in = 1; fwd_data_in = d; step(); fwd_valid_in = 0;
  endtask

  // model of the FIFO and output register, stepped on the negedge before each active edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_gvo", grad_valid_out, 0);
      chk("rst_gdo", grad_data_out, 0);
      chk("rst_cnt", mask_count, 0);
      chk("rst_frdy", fwd_ready_in, 0);
      chk("rst_grdy", grad_ready_in, 0);
      mq.delete(); sbq.delete(); ov = 0;
    end else begin
      e_frdy = !flush && mq.size() < DEPTH;
      e_grdy = !flush && mq.size() != 0 && (!ov || grad_ready_out);
      chk("mask_count", mask_count, mq.size());
      chk("fwd_ready_in", fwd_ready_in, e_frdy);
      chk("grad_ready_in", grad_ready_in, e_grdy);
      chk("grad_valid_out", grad_valid_out, ov);
      if (ov && sbq.size() != 0) chk("grad_data_out", grad_data_out, sbq[0]);
      if (ov && grad_ready_out && sbq.size() != 0) void'(sbq.pop_front());
      if (grad_valid_in && e_grdy) begin
        m = mq.pop_front();
        sbq.push_back(m ? grad_data_in : '0);
      end
      if (fwd_valid_in && e_frdy) mq.push_back(!fwd_data_in[DW-1]);
      ov = (grad_valid_in && e_grdy) ? 1'b1 : grad_ready_out ? 1'b0 : ov;
      if (flush) mq.delete();
    end
  end

  initial begin
    step(2);
    rst = 0;
    step();
    // mask gating: 5, -3, 0, 0x7FF -> 100, 0, 300, 400
    push_fwd(12'd5); push_fwd(12'hFFD); push_fwd(12'd0); push_fwd(12'h7FF);
    grad_valid_in = 1;
    foreach (sbq[i]) ;
    for (int i = 1; i <= 4; i++) begin grad_data_in = 12'(i * 100); step(); end
    grad_valid_in = 0;
    step(2);
    // full boundary: 5th sample stalls until one pop frees a slot
    for (int i = 0; i < 4; i++) push_fwd(i[0] ? 12'h800 : 12'h001);
    fwd_valid_in = 1; fwd_data_in = 12'h0AA;
    step(3);
    grad_valid_in = 1; grad_data_in = 12'h111; step(); grad_valid_in = 0;
    step(2);
    fwd_valid_in = 0;
    grad_valid_in = 1;
    for (int i = 0; i < 4; i++) begin grad_data_in = 12'h200 + 12'(i); step(); end
    grad_valid_in = 0;
    step(2);
    // empty: gradient waits until a mask arrives
    grad_valid_in = 1; grad_data_in = 12'h055;
    step(3);
    push_fwd(12'hFFF);
    step();
    grad_valid_in = 0;
    step(2);
    // backpressure: 0x123 holds, next gradient accepted on release
    push_fwd(12'h010); push_fwd(12'h020);
    grad_ready_out = 0;
    grad_valid_in = 1; grad_data_in = 12'h123; step();
    grad_data_in = 12'h456; step(3);
    grad_ready_out = 1; step();
    grad_valid_in = 0;
    step(2);
    // simultaneous push/pop at count 2 across pointer wrap
    push_fwd(12'h800); push_fwd(12'h001);
    fwd_valid_in = 1; grad_valid_in = 1;
    for (int i = 0; i < 10; i++) begin
      fwd_data_in = (i % 3 == 0) ? 12'hF00 : 12'(i);
      grad_data_in = 12'h300 + 12'(i);
      step();
    end
    fwd_valid_in = 0;
    step(2);
    grad_valid_in = 0;
    step(2);
    // async reset mid-stream with 3 masks and a held output beat
    push_fwd(12'h001); push_fwd(12'h002); push_fwd(12'h003);
    grad_ready_out = 0; grad_valid_in = 1; grad_data_in = 12'h321; step(); grad_valid_in = 0;
    #2 rst = 1;
    #1;
    chk("async_gvo", grad_valid_out, 0);
    chk("async_gdo", grad_data_out, 0);
    chk("async_cnt", mask_count, 0);
    chk("async_frdy", fwd_ready_in, 0);
    chk("async_grdy", grad_ready_in, 0);
    step(2);
    rst = 0; grad_ready_out = 1;
    step();
    // flush with 3 masks; held beat still completes
    push_fwd(12'h001); push_fwd(12'h802); push_fwd(12'h003);
    grad_ready_out = 0; grad_valid_in = 1; grad_data_in = 12'h0BC; step(); grad_valid_in = 0;
    flush = 1; step(); flush = 0;
    step();
    grad_ready_out = 1;
    step(3);
    chk("sb_drain", sbq.size(), 0);
    chk("mq_empty", mq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
